// File: rtl/jal_unit.sv
// Execute-stage JAL unit: registers the jump target (pc + imm), the link value
// (pc + 4) and a target-alignment flag one cycle after each valid request.
module jal_unit #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] link,
  output logic            misalign
);

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link_next;
  logic            misalign_next;

  // Modular adds: carries out of the top bit are intentionally dropped.
  assign target    = pc + imm;
  assign link_next = pc + XLEN'(4);

  // With compressed instructions (IALIGN=16) only bit 0 must be clear.
  always_comb begin
    misalign_next = 1'b0;
    if (IALIGN == 16)
      misalign_next = target[0];
    else
      misalign_next = |target[1:0];
  end

  // Data registers only load on a valid request so they hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      jump_addr <= '0;
      link      <= '0;
      misalign  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        jump_addr <= target;
        link      <= link_next;
        misalign  <= misalign_next;
      end
    end
  end

endmodule

// File: tb/tb_jal_unit.sv
// Self-checking bench for jal_unit: directed vector table, reset corner cases and
// randomized traffic against an arithmetic reference model, for IALIGN=32 and 16.
module tb_jal_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] pc;
  logic [31:0] imm;

  logic        out_valid32, misalign32;
  logic [31:0] jump_addr32, link32;
  logic        out_valid16, misalign16;
  logic [31:0] jump_addr16, link16;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs must show after the latest edge.
  logic        exp_valid;
  logic [31:0] exp_jump;
  logic [31:0] exp_link;
  logic        exp_mis32;
  logic        exp_mis16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] exp_jump;
    logic [31:0] exp_link;
    logic        exp_mis32;
    logic        exp_mis16;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  jal_unit #(.XLEN(32), .IALIGN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc(pc), .imm(imm),
    .out_valid(out_valid32), .jump_addr(jump_addr32), .link(link32), .misalign(misalign32)
  );

  jal_unit #(.XLEN(32), .IALIGN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc(pc), .imm(imm),
    .out_valid(out_valid16), .jump_addr(jump_addr16), .link(link16), .misalign(misalign16)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " out_valid32"}, 32'(out_valid32), 32'(exp_valid));
    checkVal({tag, " jump_addr32"}, jump_addr32, exp_jump);
    checkVal({tag, " link32"}, link32, exp_link);
    checkVal({tag, " misalign32"}, 32'(misalign32), 32'(exp_mis32));
    checkVal({tag, " out_valid16"}, 32'(out_valid16), 32'(exp_valid));
    checkVal({tag, " jump_addr16"}, jump_addr16, exp_jump);
    checkVal({tag, " link16"}, link16, exp_link);
    checkVal({tag, " misalign16"}, 32'(misalign16), 32'(exp_mis16));
  endtask

  task automatic modelReset();
    exp_valid = 1'b0;
    exp_jump  = '0;
    exp_link  = '0;
    exp_mis32 = 1'b0;
    exp_mis16 = 1'b0;
  endtask

  // Model of one clock edge, computed with wide arithmetic and modulo 2^32.
  task automatic modelEdge(input logic v, input logic [31:0] p, input logic [31:0] i);
    logic [63:0] sum;
    logic [63:0] lnk;
    exp_valid = v;
    if (v) begin
      sum       = (64'(p) + 64'(i)) % 64'h1_0000_0000;
      lnk       = (64'(p) + 64'd4) % 64'h1_0000_0000;
      exp_jump  = sum[31:0];
      exp_link  = lnk[31:0];
      exp_mis32 = (sum % 64'd4) != 64'd0;
      exp_mis16 = (sum % 64'd2) != 64'd0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] p, input logic [31:0] i);
    @(negedge clk);
    in_valid = v;
    pc       = p;
    imm      = i;
    @(posedge clk);
    #1;
    modelEdge(v, p, i);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h0000_0100, 32'h0000_1100, 32'h0000_1004, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 32'h0000_1004, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFF4, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_1000, 32'h0000_0002, 32'h0000_1002, 32'h0000_1004, 1'b1, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    pc       = '0;
    imm      = '0;
    modelReset();
    #2;
    checkOutput("reset");

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h1234_5678, 32'h0000_0004);
    checkOutput("idle after reset");

    // Directed vectors, streamed back to back.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, vecs[k].pc, vecs[k].imm);
      checkVal($sformatf("vec%0d out_valid", k), 32'(out_valid32), 32'd1);
      checkVal($sformatf("vec%0d jump_addr", k), jump_addr32, vecs[k].exp_jump);
      checkVal($sformatf("vec%0d link", k), link32, vecs[k].exp_link);
      checkVal($sformatf("vec%0d misalign32", k), 32'(misalign32), 32'(vecs[k].exp_mis32));
      checkVal($sformatf("vec%0d misalign16", k), 32'(misalign16), 32'(vecs[k].exp_mis16));
    end

    // Odd target: misaligned for both alignments; then hold on an idle cycle.
    applyStimulus(1'b1, 32'h0000_2000, 32'h0000_0001);
    checkOutput("odd target");
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0000_0003);
    checkOutput("hold");

    // Reset between edges while a result is showing and another op is in flight.
    applyStimulus(1'b1, 32'h0000_3000, 32'h0000_0040);
    checkOutput("pre-reset op");
    @(negedge clk);
    in_valid = 1'b1;
    pc       = 32'h0000_4000;
    imm      = 32'h0000_0006;
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async reset");
    @(posedge clk);
    #1;
    checkOutput("reset held over edge");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    modelEdge(1'b0, pc, imm);
    checkOutput("release idle");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic        v;
      logic [31:0] p;
      logic [31:0] i;
      v = ($urandom_range(0, 3) != 0);
      p = $urandom();
      i = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed(12'($urandom_range(0, 4095))));
      applyStimulus(v, p, i);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
